cga_vram_arbiter: RTL

Shares the single 8-bit video SRAM between the CGA display fetch path and CPU memory cycles in the B8000-BFFFF window.
- The display always has priority.
- CPU accesses are placed only in sequencer-granted slots (isa_op_enable) and are stretched with bus_rdy wait states until they complete.
- Sits between the ISA bus pins, the cga sequencer/pixel path and the SRAM pins.

---
 rtl/cga_vram_arbiter_if.sv | 33 +++
 rtl/cga_vram_arbiter.sv | 119 +++++++++++
 2 files changed

// File: rtl/cga_vram_arbiter_if.sv
// ISA-side, display-side and SRAM-side signals of the CGA video RAM arbiter.
// slave is the arbiter's view; master is the view of whatever surrounds it.
interface cga_vram_arbiter_if;
  logic [19:0] bus_a;
  logic        bus_memr_l;
  logic        bus_memw_l;
  logic        bus_aen;
  logic [7:0]  bus_d;
  logic [7:0]  bus_out;
  logic        bus_dir;
  logic        bus_rdy;
  logic [18:0] disp_a;
  logic        disp_read;
  logic        isa_op_enable;
  logic [18:0] ram_a;
  logic        ram_we_l;
  logic [7:0]  ram_d_out;
  logic        ram_d_oe;
  logic [7:0]  ram_d;
  logic        cpu_busy;

  modport slave (
    input  bus_a, bus_memr_l, bus_memw_l, bus_aen, bus_d,
    input  disp_a, disp_read, isa_op_enable, ram_d,
    output bus_out, bus_dir, bus_rdy, ram_a, ram_we_l, ram_d_out, ram_d_oe, cpu_busy
  );

  modport master (
    output bus_a, bus_memr_l, bus_memw_l, bus_aen, bus_d,
    output disp_a, disp_read, isa_op_enable, ram_d,
    input  bus_out, bus_dir, bus_rdy, ram_a, ram_we_l, ram_d_out, ram_d_oe, cpu_busy
  );
endinterface

// File: rtl/cga_vram_arbiter.sv
// Shares the 8-bit CGA video SRAM between display fetches (always first) and
// CPU cycles in the B8000-BFFFF window, stalling the ISA bus with bus_rdy.
module cga_vram_arbiter #(
  parameter logic [19:0] FRAMEBUFFER_ADDR = 20'hB8000,
  parameter logic [3:0]  RAM_BASE         = 4'b0001,
  parameter int          ACCESS_CYCLES    = 2,
  parameter bit          USE_BUS_WAIT     = 1'b1
) (
  input logic              clk,
  input logic              reset,
  cga_vram_arbiter_if.slave vif
);

  localparam logic [2:0] CNT_LAST = 3'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_SLOT, ACCESS, DONE} state_t;

  state_t      state_q;
  logic        rd_m_q, rd_s_q, wr_m_q, wr_s_q;
  logic        req_lvl_q;
  logic        is_wr_q;
  logic [2:0]  cnt_q;
  logic        bus_rdy_q;
  logic [7:0]  bus_out_q;
  logic [14:0] addr_q;
  logic [7:0]  data_q;

  logic mem_cs;
  logic req_lvl_d;
  logic req_rise;
  logic strobe_held;
  logic cpu_drive;

  assign mem_cs      = (vif.bus_a[19:15] == FRAMEBUFFER_ADDR[19:15]) & ~vif.bus_aen;
  // Both strobes at once cancel out here, so such a cycle never raises a request.
  assign req_lvl_d   = rd_s_q ^ wr_s_q;
  assign req_rise    = req_lvl_d & ~req_lvl_q & mem_cs;
  assign strobe_held = is_wr_q ? wr_s_q : rd_s_q;
  // The display wins the SRAM combinationally, even in the middle of a CPU access.
  assign cpu_drive   = (state_q == ACCESS) & ~vif.disp_read;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_m_q    <= 1'b0;
      rd_s_q    <= 1'b0;
      wr_m_q    <= 1'b0;
      wr_s_q    <= 1'b0;
      req_lvl_q <= 1'b0;
    end else begin
      rd_m_q    <= ~vif.bus_memr_l;
      rd_s_q    <= rd_m_q;
      wr_m_q    <= ~vif.bus_memw_l;
      wr_s_q    <= wr_m_q;
      req_lvl_q <= req_lvl_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      is_wr_q   <= 1'b0;
      cnt_q     <= 3'd0;
      bus_rdy_q <= 1'b1;
      bus_out_q <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_rise) begin
            is_wr_q   <= wr_s_q;
            bus_rdy_q <= 1'b0;
            state_q   <= WAIT_SLOT;
          end
        end
        WAIT_SLOT: begin
          if (!strobe_held) begin
            bus_rdy_q <= 1'b1;
            state_q   <= IDLE;
          end else if (vif.isa_op_enable && !vif.disp_read) begin
            cnt_q   <= 3'd0;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          // A display steal restarts the whole access at the next granted slot.
          if (vif.disp_read) begin
            state_q <= WAIT_SLOT;
          end else if (cnt_q == CNT_LAST) begin
            if (!is_wr_q) bus_out_q <= vif.ram_d;
            bus_rdy_q <= 1'b1;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        DONE: begin
          if (!rd_s_q && !wr_s_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && req_rise) begin
      addr_q <= vif.bus_a[14:0];
      data_q <= vif.bus_d;
    end
  end

  assign vif.bus_dir   = mem_cs & ~vif.bus_memr_l;
  assign vif.bus_rdy   = USE_BUS_WAIT ? bus_rdy_q : 1'b1;
  assign vif.bus_out   = bus_out_q;
  assign vif.cpu_busy  = (state_q == WAIT_SLOT) | (state_q == ACCESS);
  assign vif.ram_a     = cpu_drive ? {RAM_BASE, addr_q} : vif.disp_a;
  assign vif.ram_we_l  = ~(cpu_drive & is_wr_q);
  assign vif.ram_d_oe  = cpu_drive & is_wr_q;
  assign vif.ram_d_out = data_q;

endmodule
